// File: rtl/sort_result_streamer_if.sv
// Signal bundle between the result streamer and its environment: sort completion,
// the memory read port, and the output word stream with its status flags.
interface sort_result_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              sort_done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              order_err;
  logic              stream_done;

  modport master (
    input  sort_done, mem_rdata, out_ready,
    output mem_rd, mem_addr, busy, out_valid, out_data, out_last, order_err, stream_done
  );

  modport slave (
    output sort_done, mem_rdata, out_ready,
    input  mem_rd, mem_addr, busy, out_valid, out_data, out_last, order_err, stream_done
  );
endinterface

// File: rtl/sort_result_streamer.sv
// Streams the sorted memory out in address order after the sort completes,
// alternating a fetch cycle with an offer cycle, and flags any descending neighbour pair.
module sort_result_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  sort_result_streamer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      prev_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    prev_d  = prev_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (bus.sort_done) begin
        addr_d  = '0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: begin
        data_d  = bus.mem_rdata;
        prev_d  = bus.mem_rdata;
        // The first word has no predecessor; prev is stale from the last run.
        if (addr_q != '0 && bus.mem_rdata < prev_q) err_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (bus.out_ready) begin
        if (addr_q == LAST) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd      = (state_q == FETCH);
  assign bus.mem_addr    = addr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == SEND);
  assign bus.out_data    = data_q;
  assign bus.out_last    = (state_q == SEND) && (addr_q == LAST);
  assign bus.order_err   = err_q;
  assign bus.stream_done = (state_q == FIN);

endmodule

// File: doc/sort_result_streamer.md
# sort_result_streamer

Downstream stage of the memory exchange-sort controller. After the sorter signals completion, this block takes the shared data memory and reads out all words in address order. It presents them on a valid/ready output stream, tagging the last word. It also checks that the sequence is non-decreasing and raises a sticky error flag if it is not.

## Interface
- DATA_W, 8, width of a memory word
- ADDR_W, 4, memory address width
- DEPTH, 16, number of words streamed (1 ≤ DEPTH ≤ 2**ADDR_W)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sort_done  in  1  one-cycle completion pulse from the sort controller
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data; combinational, valid in the same cycle as mem_addr
- busy  out  1  high whenever state ≠ IDLE; top level uses it to give this block the memory address mux
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_W  streamed word (registered)
- out_last  out  1  high with out_valid when the word comes from address DEPTH-1
- order_err  out  1  sticky: some word was less than its predecessor (unsigned)
- stream_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- The FSM has four states: IDLE, FETCH, SEND, FIN. Registers: addr (ADDR_W), out_data, prev (DATA_W), order_err.
- IDLE
  - All strobes are 0.
  - If sort_done=1: addr←0, order_err←0, go to FETCH.
- FETCH
  - mem_rd=1, mem_addr=addr.
  - At the clock edge: out_data←mem_rdata, prev←mem_rdata, go to SEND.
  - If addr≠0 and mem_rdata<prev: order_err←1.
- SEND
  - out_valid=1, out_data is held stable.
  - If out_ready=0: stay in SEND.
  - If out_ready=1 and addr=DEPTH-1: go to FIN.
  - If out_ready=1 otherwise: addr←addr+1, go to FETCH.
- FIN: stream_done=1 for one cycle, then go to IDLE.
- out_last = (state=SEND) && (addr=DEPTH-1).
- mem_addr equals addr in every state; mem_rd=1 only in FETCH.
- sort_done is ignored whenever state ≠ IDLE.
- order_err holds its value through IDLE. It clears only on an accepted sort_done or on rst.
- The comparison is unsigned at DATA_W bits; equal neighbours are legal.
- DEPTH=1: the single word has out_last=1 and order_err stays 0.

## Timing
- Reset values: state=IDLE, addr=0, out_data=0, prev=0, order_err=0. All outputs are 0, including mem_addr=0.
- Asserting rst mid-stream aborts immediately to reset values. No stream_done is produced. The word being offered is dropped.
- Latency, with sort_done sampled at edge 0:
  - FETCH during cycle 1.
  - First out_valid in cycle 2.
- Throughput: one word per 2 cycles when out_ready is held high. FETCH and SEND alternate.
  - Word k is offered in cycle 2k+2.
  - stream_done is high in cycle 2·DEPTH+1.
- Handshake: a transfer occurs on a rising edge where out_valid & out_ready. Once out_valid rises, out_data and out_last do not change until that transfer. out_valid does not depend combinationally on out_ready.
- order_err updates on the FETCH edge, so it is visible while the offending word is offered.
- addr never wraps. It stops at DEPTH-1.

## Test plan
- Memory holds 0..15, DEPTH=16, out_ready=1, pulse sort_done → 16 words 0..15 offered in cycles 2,4,…,32. out_last only with word 15. stream_done in cycle 33. order_err=0, busy falls after FIN.
- Same memory, out_ready toggled randomly (stalls up to 5 cycles) → exactly 16 transfers in order. No duplicates or drops. out_data stable during every stall.
- Memory {1,2,3,9,4,5,…}, out_ready=1 → order_err rises while word 4 (address 4) is offered. It stays 1 after stream_done. A new sort_done clears it.
- Memory all 0x7F → 16 words of 0x7F, order_err=0 (equal values legal).
- Extra sort_done pulse at cycle 10 while streaming → ignored. Stream count stays 16, addr is not reset.
- rst asserted while in SEND at addr=6 → all outputs 0 immediately, no stream_done. A following sort_done restarts from addr 0.
